// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg
//   Shared types for the pipeline hazard/forwarding control block.
//   fwd_sel_t  : EX-stage operand source select (register file, WB, MEM).
//   hz_state_t : hazard state machine (normal run, waiting on dcache, halted).
package pipeline_control_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DWAIT  = 2'b01,
        HALTED = 2'b10
    } hz_state_t;

endpackage

// File: rtl/pipeline_control_forward.sv
// forward_unit
//   Combinational EX-stage operand forwarding select.
//   Ports:
//     ex_rs, ex_rt            EX-stage source registers (operand a / b)
//     mem_rd, mem_regwen      MEM-stage destination and write enable
//     wb_rd, wb_regwen        WB-stage destination and write enable
//     fwd_a, fwd_b            operand select; always FWD_RF when FWD_EN=0
module forward_unit
    import pipeline_control_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwen,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b
);

    // MEM holds the younger result, so it takes priority over WB.
    // Register 0 is hard-wired zero and is never forwarded.
    function automatic fwd_sel_t pick(input logic [REG_AW-1:0] src);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (FWD_EN) begin
            if (mem_regwen && mem_rd != '0 && mem_rd == src)
                sel = FWD_MEM;
            else if (wb_regwen && wb_rd != '0 && wb_rd == src)
                sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = pick(ex_rs);
        fwd_b = pick(ex_rt);
    end

endmodule

// File: rtl/pipeline_control.sv
// pipeline_control
//   Stall/flush control and operand forwarding for a five-stage pipeline.
//   Ports:
//     CLK, RST                      clock, synchronous active-high reset
//     ihit, dhit                    icache / dcache hit
//     mem_dren, mem_dwen            MEM-stage data read / write request
//     redirect                      control transfer resolved in EX
//     wb_halt                       HALT instruction in WB
//     id_rs, id_rt, id_uses_rt      ID-stage sources
//     ex_rs, ex_rt                  EX-stage sources
//     ex_rd/mem_rd/wb_rd, *_regwen  destinations and write enables
//     ex_memread                    EX instruction is a load
//     pc_en..mem_en                 PC and latch write enables
//     if_flush, id_flush            bubble insert into IF/ID, ID/EX
//     fwd_a, fwd_b                  EX operand selects
//     halt                          registered halted flag
//     stall_cnt                     saturating count of cycles with pc_en=0
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              mem_dren,
    input  logic              mem_dwen,
    input  logic              redirect,
    input  logic              wb_halt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              ex_regwen,
    input  logic              mem_regwen,
    input  logic              wb_regwen,
    input  logic              ex_memread,
    output logic              pc_en,
    output logic              if_en,
    output logic              id_en,
    output logic              ex_en,
    output logic              mem_en,
    output logic              if_flush,
    output logic              id_flush,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b,
    output logic              halt,
    output logic [CNT_W-1:0]  stall_cnt
);

    hz_state_t state;
    logic      dmiss;
    logic      halted_now;
    logic      raw_ex, raw_mem, raw_wb;
    logic      load_use;

    // True when an older instruction writing rd feeds an ID-stage source.
    function automatic logic id_dep(input logic wen, input logic [REG_AW-1:0] rd);
        return wen && rd != '0 &&
               (rd == id_rs || (id_uses_rt && rd == id_rt));
    endfunction

    always_comb begin
        dmiss      = (mem_dren | mem_dwen) & ~dhit;
        // Reset forces RUN behaviour in the reset cycle itself.
        halted_now = (state == HALTED) && !RST;
        raw_ex     = id_dep(ex_regwen, ex_rd);
        raw_mem    = id_dep(mem_regwen, mem_rd);
        raw_wb     = id_dep(wb_regwen, wb_rd);
        // Without forwarding every RAW dependency in flight must drain.
        load_use   = FWD_EN ? (ex_memread & raw_ex) : (raw_ex | raw_mem | raw_wb);

        pc_en    = 1'b1;
        if_en    = 1'b1;
        id_en    = 1'b1;
        ex_en    = 1'b1;
        mem_en   = 1'b1;
        if_flush = 1'b0;
        id_flush = 1'b0;

        if (halted_now || dmiss) begin
            // Whole pipe frozen; redirect stays in EX and is applied later.
            pc_en  = 1'b0;
            if_en  = 1'b0;
            id_en  = 1'b0;
            ex_en  = 1'b0;
            mem_en = 1'b0;
        end else if (redirect) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            if_en    = 1'b0;
            id_flush = 1'b1;
        end else if (!ihit) begin
            pc_en    = 1'b0;
            if_flush = 1'b1;
        end
    end

    forward_unit #(
        .REG_AW (REG_AW),
        .FWD_EN (FWD_EN)
    ) u_fwd (
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .mem_rd     (mem_rd),
        .mem_regwen (mem_regwen),
        .wb_rd      (wb_rd),
        .wb_regwen  (wb_regwen),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (!pc_en && state != HALTED && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);

            // A halt cannot retire while its memory access is still missing.
            if (wb_halt && !dmiss) begin
                state <= HALTED;
                halt  <= 1'b1;
            end else begin
                case (state)
                    RUN:     if (dmiss)  state <= DWAIT;
                    DWAIT:   if (!dmiss) state <= RUN;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Parametrised successor to the five-stage pipeline's hazard logic, folding stall/flush control and operand forwarding into one block between the control unit, caches and pipeline latches. Adds a registered state machine for data-cache misses and halt, precise load-use detection, a selectable no-forwarding mode, and a saturating stall counter. Each cycle it drives every latch enable/flush, the PC enable and the EX-stage operand selects.

## Interface
- REG_AW, 5: register index width
- FWD_EN, 1: 1 = forwarding plus load-use stall; 0 = no forwarding, stall on any RAW hazard
- CNT_W, 16: stall counter width
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- ihit, dhit  in  1  icache / dcache hit
- mem_dren, mem_dwen  in  1  MEM-stage data read / write request
- redirect  in  1  taken branch, J, JAL or JR resolved in EX
- wb_halt  in  1  HALT in WB stage
- id_rs, id_rt  in  REG_AW  ID-stage sources; id_uses_rt  in  1  rt is a source
- ex_rs, ex_rt  in  REG_AW  EX-stage sources
- ex_rd, mem_rd, wb_rd  in  REG_AW  destinations; ex_regwen, mem_regwen, wb_regwen  in  1
- ex_memread  in  1  EX instruction is a load
- pc_en, if_en, id_en, ex_en, mem_en  out  1  PC / latch write enables
- if_flush, id_flush  out  1  IF/ID, ID/EX insert bubble
- fwd_a, fwd_b  out  2  EX operand select (fwd_sel_t)
- halt  out  1  registered; pipeline halted
- stall_cnt  out  CNT_W  cycles with pc_en=0

## Operation
- States: RUN, DWAIT, HALTED (hz_state_t). RST -> RUN.
- dmiss = (mem_dren|mem_dwen) & !dhit. RUN -> DWAIT on dmiss; DWAIT -> RUN when dhit or request drops; any state -> HALTED when wb_halt & !dmiss; HALTED left only by RST.
- Outputs, first match wins:
  1. HALTED: all enables 0, flushes 0.
  2. dmiss: all enables 0, flushes 0 (whole pipe frozen; redirect/hazards re-evaluated after).
  3. redirect: all enables 1, if_flush=id_flush=1 (two wrong-path instructions killed); ihit ignored.
  4. load-use (FWD_EN=1): ex_memread & ex_regwen & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)); FWD_EN=0 also matches mem_rd/mem_regwen and wb_rd/wb_regwen, any opcode: pc_en=if_en=0, id_flush=1, id_en=ex_en=mem_en=1.
  5. !ihit: pc_en=0, if_flush=1, rest 1.
  6. otherwise all enables 1, flushes 0.
- Forwarding (operand a on ex_rs, b on ex_rt): FWD_MEM if mem_regwen & mem_rd!=0 & match; else FWD_WB if wb_regwen & wb_rd!=0 & match; else FWD_RF. FWD_EN=0: always FWD_RF. Register 0 never forwarded.
- stall_cnt increments when pc_en=0 and state!=HALTED; saturates at all-ones.

## Timing
- Enables, flushes, fwd_* combinational from inputs and current state, same cycle; no added latency.
- State, halt, stall_cnt registered on CLK rising edge. halt=1 the cycle after wb_halt sampled.
- Reset values: state RUN, halt 0, stall_cnt 0. During RST cycle combinational outputs follow rules with state=RUN.
- RST mid-DWAIT or HALTED: RUN next edge, counter cleared.
- Load-use stall exactly one cycle under FWD_EN=1 (load moves to MEM, hazard clears); FWD_EN=0 up to three.
- dmiss and redirect same cycle: freeze; redirect applied on the dhit cycle as it is still held in EX.

## Structure
- cpu_types_pkg gains fwd_sel_t (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10) and hz_state_t (RUN, DWAIT, HALTED).
- New interface pipeline_control_if.vh with modports for this block and the datapath.
- Sub-module forward_unit: combinational fwd_a/fwd_b, parametrised on REG_AW and FWD_EN.

## Test plan
- Load r3 in EX, ID uses rs=3, ihit=1 -> one cycle pc_en=0, if_en=0, id_flush=1, stall_cnt 0->1; next cycle all enables 1.
- mem_dren=1, dhit=0 for 4 cycles then 1 -> DWAIT 4 cycles, all enables 0, stall_cnt=4, RUN after dhit cycle.
- redirect=1 with ihit=0 -> pc_en=1, if_flush=id_flush=1 same cycle.
- mem_rd=wb_rd=5, both regwen, ex_rs=5 -> fwd_a=FWD_MEM; ex_rt=0 with mem_rd=0 -> fwd_b=FWD_RF; FWD_EN=0 -> both FWD_RF.
- wb_halt=1 -> halt=1 next cycle, enables 0 thereafter despite ihit; RST=1 -> halt=0, stall_cnt=0.
- CNT_W=4, 20 miss cycles -> stall_cnt saturates at 15.
